m_upload: RTL
=============

Name: m_upload

Overview:
- Memory-side injection stage of the ring-network node; mirror of the memory download collector.
- Accepts one complete response message (up to 11 × 16-bit flits, packed in 176 bits) from the memory controller.
- Serializes the message onto the ring injection port one flit at a time, with head/body/tail control codes and a valid/ack handshake.

Parameters:
- FLIT_W, 16: flit width in bits.
- MAX_FLITS, 11: maximum flits per message. The message bus is FLIT_W*MAX_FLITS = 176 bits.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- v_m_upload_in  in  1  memory presents a message
- m_upload_flits_in  in  176  message; flit 0 in [15:0], flit k in [16k+15:16k]
- m_upload_flit_num  in  4  number of flits in the message (1..11)
- m_upload_ack  out  1  one-cycle pulse: message captured
- OUT_flit_mem  out  16  current flit to the ring
- v_OUT_flit_mem  out  1  OUT_flit_mem/OUT_flit_ctrl valid
- OUT_flit_ctrl  out  2  00 none, 01 head, 10 body, 11 tail
- OUT_flit_ack  in  1  ring accepted the current flit this cycle
- m_upload_state  out  2  current FSM state

Behaviour:
- Reset (rst=1 at a clock edge) has these effects:
  - State goes to IDLE; flit regs, cnt and num clear to 0.
  - m_upload_ack=0, v_OUT_flit_mem=0, OUT_flit_mem=16'h0000, OUT_flit_ctrl=00.
  - Reset mid-message abandons the message; no tail is sent.
- State encoding: IDLE=2'b00, BUSY=2'b01. 2'b10 is unused and decodes to IDLE.
- IDLE:
  - If v_m_upload_in=1: capture all 176 bits and num, set cnt=0, go to BUSY.
  - m_upload_ack=1 combinationally in that cycle.
  - Outputs invalid while in IDLE.
- num rule: m_upload_flit_num of 0 or 12..15 saturates to 11.
- BUSY:
  - v_OUT_flit_mem=1, OUT_flit_mem=flit[cnt].
  - OUT_flit_ctrl: 11 if cnt==num-1 (this includes single-flit messages); otherwise 01 if cnt==0; otherwise 10.
  - On OUT_flit_ack: if cnt==num-1, go to IDLE and clear regs/cnt; else cnt=cnt+1.
  - Without ack, OUT_flit_mem and OUT_flit_ctrl hold stable indefinitely.
- v_m_upload_in while BUSY is ignored: no ack, no capture. Memory holds its request until acked.
- Latency:
  - Capture at edge T; head flit valid from T+1.
  - With continuous ack, an n-flit message occupies cycles T+1..T+n.
  - IDLE is re-entered at T+n+1; the next message can be captured that cycle, so the minimum gap is one idle cycle.
- OUT_flit_ack while in IDLE is ignored.
- cnt is 4 bits and never exceeds 10; no wrap-around.

Optional Feature:
- Macro: M_UPLOAD_STAT_EN.
- Defined:
  - Extra output m_upload_msg_cnt [15:0]: count of completed messages.
  - Increments on the tail-flit ack and wraps 16'hFFFF→0.
  - Cleared by rst.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package ring_mem_pkg holds:
  - FLIT_W and MAX_FLITS.
  - Ctrl codes CTRL_NONE/HEAD/BODY/TAIL (shared with the download collector, whose tail detection uses 11).
  - State encodings IDLE/BUSY.
- One sub-module, m_upload_flit_sel: purely combinational 11:1 flit mux plus ctrl-code generation from cnt/num.
- FSM, registers and counter stay in m_upload.

Test Plan:
- 11-flit message with flit k = 16'hA000+k and OUT_flit_ack held 1:
  - ack pulse at T.
  - Flits A000..A00A on T+1..T+11.
  - ctrl sequence 01, 10×9, 11.
  - IDLE at T+12.
- Single flit, num=1, data 16'h1234: one cycle with ctrl=11 and data 1234, then IDLE.
- 3-flit message with OUT_flit_ack low for 4 cycles on flit 1: flit 1 and ctrl=10 held stable for 4 cycles, then normal completion; total 7 valid cycles.
- num=0 and num=15 each → 11 flits emitted, last ctrl=11. Also: v_m_upload_in asserted during BUSY → no ack, in-flight data unchanged.
- rst asserted after flit 2 of 5 → next cycle IDLE, v_OUT_flit_mem=0, cnt=0. A new message then starts with head flit 0.
- With M_UPLOAD_STAT_EN: send 3 messages → m_upload_msg_cnt=3. Preload 16'hFFFF then send one → 0.

Source files
------------

// File: rtl/ring_mem_pkg.sv
//------------------------------------------------------------------------------
// Module : ring_mem_pkg
// Brief  : Shared flit geometry, ctrl codes and FSM encodings for the ring
//          memory upload/download path.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ring_mem_pkg;

  localparam int FLIT_W    = 16;
  localparam int MAX_FLITS = 11;
  localparam int MSG_W     = FLIT_W * MAX_FLITS;
  localparam int CNT_W     = 4;

  localparam logic [1:0] CTRL_NONE = 2'b00;
  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01
  } state_e;

  // Out-of-range flit counts (0, 12..15) are treated as a full message.
  function automatic logic [CNT_W-1:0] sat_flit_num(input logic [CNT_W-1:0] n);
    if ((n == '0) || (n > CNT_W'(MAX_FLITS)))
      return CNT_W'(MAX_FLITS);
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_upload_if.sv
//------------------------------------------------------------------------------
// Module : m_upload_if
// Brief  : Memory-message and ring-injection signals of the upload stage.
//          Message counter present only when M_UPLOAD_STAT_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface m_upload_if;
  import ring_mem_pkg::*;

  logic                    v_m_upload_in;
  logic [MSG_W-1:0]        m_upload_flits_in;
  logic [CNT_W-1:0]        m_upload_flit_num;
  logic                    m_upload_ack;
  logic [FLIT_W-1:0]       OUT_flit_mem;
  logic                    v_OUT_flit_mem;
  logic [1:0]              OUT_flit_ctrl;
  logic                    OUT_flit_ack;
  logic [1:0]              m_upload_state;
`ifdef M_UPLOAD_STAT_EN
  logic [15:0]             m_upload_msg_cnt;
`endif

  // Environment side: memory controller and ring port.
  modport master (
    output v_m_upload_in, m_upload_flits_in, m_upload_flit_num, OUT_flit_ack,
`ifdef M_UPLOAD_STAT_EN
    input  m_upload_msg_cnt,
`endif
    input  m_upload_ack, OUT_flit_mem, v_OUT_flit_mem, OUT_flit_ctrl, m_upload_state
  );

  modport slave (
    input  v_m_upload_in, m_upload_flits_in, m_upload_flit_num, OUT_flit_ack,
`ifdef M_UPLOAD_STAT_EN
    output m_upload_msg_cnt,
`endif
    output m_upload_ack, OUT_flit_mem, v_OUT_flit_mem, OUT_flit_ctrl, m_upload_state
  );

endinterface

`default_nettype wire

// File: rtl/m_upload_flit_sel.sv
//------------------------------------------------------------------------------
// Module : m_upload_flit_sel
// Brief  : Combinational flit selector and head/body/tail code generator.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_upload_flit_sel
  import ring_mem_pkg::*;
(
  input  wire logic [MSG_W-1:0]  flits,
  input  wire logic [CNT_W-1:0]  cnt,
  input  wire logic [CNT_W-1:0]  num,
  output logic      [FLIT_W-1:0] flit,
  output logic      [1:0]        ctrl
);

  logic [FLIT_W-1:0] w_flit_arr [MAX_FLITS];

  for (genvar gi = 0; gi < MAX_FLITS; gi++) begin : g_unpack
    assign w_flit_arr[gi] = flits[gi*FLIT_W +: FLIT_W];
  end

  always_comb begin
    flit = '0;
    for (int i = 0; i < MAX_FLITS; i++) begin
      if (cnt == CNT_W'(i))
        flit = w_flit_arr[i];
    end
  end

  // Tail takes priority so a single-flit message is marked tail, not head.
  always_comb begin
    ctrl = CTRL_BODY;
    if (cnt == (num - CNT_W'(1)))
      ctrl = CTRL_TAIL;
    else if (cnt == '0)
      ctrl = CTRL_HEAD;
  end

endmodule

`default_nettype wire

// File: rtl/m_upload.sv
//------------------------------------------------------------------------------
// Module : m_upload
// Brief  : Captures a memory response message and serialises it onto the ring
//          injection port. Define M_UPLOAD_STAT_EN for the message counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_upload
  import ring_mem_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst,
  m_upload_if.slave    bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [MSG_W-1:0]   r_flits;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_num;
  logic               w_capture;
  logic               w_advance;
  logic               w_finish;
  logic               w_busy;
  logic [FLIT_W-1:0]  w_sel_flit;
  logic [1:0]         w_sel_ctrl;

  m_upload_flit_sel u_flit_sel (
    .flits (r_flits),
    .cnt   (r_cnt),
    .num   (r_num),
    .flit  (w_sel_flit),
    .ctrl  (w_sel_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Any encoding other than BUSY behaves as IDLE.
  always_comb begin
    w_state_nxt = IDLE;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      BUSY: begin
        w_state_nxt = BUSY;
        if (bus.OUT_flit_ack) begin
          if (w_sel_ctrl == CTRL_TAIL) begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: begin
        if (bus.v_m_upload_in) begin
          w_capture   = 1'b1;
          w_state_nxt = BUSY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_finish) begin
      r_flits <= '0;
      r_cnt   <= '0;
      r_num   <= '0;
    end else if (w_capture) begin
      r_flits <= bus.m_upload_flits_in;
      r_num   <= sat_flit_num(bus.m_upload_flit_num);
      r_cnt   <= '0;
    end else if (w_advance) begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign w_busy             = (r_state == BUSY);
  assign bus.m_upload_ack   = w_capture;
  assign bus.v_OUT_flit_mem = w_busy;
  assign bus.OUT_flit_mem   = w_busy ? w_sel_flit : '0;
  assign bus.OUT_flit_ctrl  = w_busy ? w_sel_ctrl : CTRL_NONE;
  assign bus.m_upload_state = r_state;

`ifdef M_UPLOAD_STAT_EN
  logic [15:0] r_msg_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_msg_cnt <= '0;
    else if (w_finish)
      r_msg_cnt <= r_msg_cnt + 16'd1;
  end

  assign bus.m_upload_msg_cnt = r_msg_cnt;
`endif

endmodule

`default_nettype wire
